// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator: counters, sync/DE decode, coordinates and strobes.
// Optional macro VGA_TIMING_SYNC_DLY_EN delays VGA_HS/VGA_VS/data_en by SYNC_DLY extra clocks.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 12,
  parameter int SYNC_DLY = 2
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             en,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             data_en,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: ~HS_ON, vs: ~VS_ON, de: 1'b0};

  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_cnt_w
    $error("CNT_W too narrow for raster totals");
  end
  if (SYNC_DLY < 0) begin : g_bad_dly
    $error("SYNC_DLY must be non-negative");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  sync_t            dec, src;

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    dec    = SYNC_IDLE;
    dec.hs = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ~^ HS_ON;
    dec.vs = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ~^ VS_ON;
    dec.de = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  end

`ifdef VGA_TIMING_SYNC_DLY_EN
  // Pins lag the coordinates so the frame-buffer read has time to return data.
  localparam int DLY = (SYNC_DLY < 1) ? 1 : SYNC_DLY;
  sync_t [DLY-1:0] dly_pipe;

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DLY; i++) dly_pipe[i] <= SYNC_IDLE;
    end else if (en) begin
      dly_pipe[0] <= dec;
      for (int i = 1; i < DLY; i++) dly_pipe[i] <= dly_pipe[i-1];
    end
  end

  assign src = dly_pipe[DLY-1];
`else
  assign src = dec;
`endif

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      VGA_HS      <= ~HS_ON;
      VGA_VS      <= ~VS_ON;
      data_en     <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      VGA_HS      <= src.hs;
      VGA_VS      <= src.vs;
      data_en     <= src.de;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      // Frozen raster: sync levels and coordinates hold, anything that marks pixels drops.
      data_en     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; reference model tracks the linear pixel index.
module tb_vga_timing_gen;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int HSP = 0, VSP = 1, W = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic pixel_clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic VGA_HS, VGA_VS, data_en, line_start, frame_start;
  logic [W-1:0] pixel_x, pixel_y;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .CNT_W(W), .SYNC_DLY(2)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .en(en),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .data_en(data_en),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference: p is the linear raster position the next enabled edge will present.
  int   p;
  logic e_hs, e_vs, e_de, e_ls, e_fs;
  int   e_x, e_y;

  wire [20:0] dut_vec = {VGA_HS, VGA_VS, data_en, line_start, frame_start, pixel_x, pixel_y};

  function automatic logic [20:0] exp_vec();
    return {e_hs, e_vs, e_de, e_ls, e_fs, W'(e_x), W'(e_y)};
  endfunction

  task automatic model_reset();
    p = 0; e_x = 0; e_y = 0;
    e_hs = !HSP[0]; e_vs = !VSP[0];
    e_de = 0; e_ls = 0; e_fs = 0;
  endtask

  task automatic model_edge();
    int h, v;
    if (!rst) return;
    if (en) begin
      h = p % HT; v = p / HT;
      e_x = h; e_y = v;
      e_de = (h < HA) && (v < VA);
      e_hs = (h >= HA + HF && h < HA + HF + HS) ? HSP[0] : !HSP[0];
      e_vs = (v >= VA + VF && v < VA + VF + VS) ? VSP[0] : !VSP[0];
      e_ls = (h == 0);
      e_fs = (h == 0) && (v == 0);
      p = (p + 1) % FRAME;
    end else begin
      e_de = 0; e_ls = 0; e_fs = 0;
    end
  endtask

  // One clock: edge, model update, settle; inputs change only here (1ns after the edge).
  task automatic step();
    @(posedge pixel_clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 0; en = 1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    rst = 1;
    step();
    checks++;
    if (dut_vec !== exp_vec() || frame_start !== 1'b1 || data_en !== 1'b1) begin
      fails++;
      $display("FAIL first_edge got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_run();
    int last_fs = -1, last_ls = -1, de_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL run t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (data_en) de_cnt++;
      if (frame_start) begin
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != FRAME) begin
            fails++;
            $display("FAIL fs_period got=%0d exp=%0d", cyc - last_fs, FRAME);
          end
        end
        last_fs = cyc;
      end
      if (line_start) begin
        if (last_ls >= 0) begin
          checks++;
          if (cyc - last_ls != HT) begin
            fails++;
            $display("FAIL ls_period got=%0d exp=%0d", cyc - last_ls, HT);
          end
        end
        last_ls = cyc;
      end
    end
    checks++;
    if (de_cnt != 2 * HA * VA) begin
      fails++;
      $display("FAIL de_count got=%0d exp=%0d", de_cnt, 2 * HA * VA);
    end
  endtask

  task automatic test_en_random();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL en_rand t=%0d en=%0b got=%h exp=%h", cyc, en, dut_vec, exp_vec());
      end
    end
    en = 1;
  endtask

  task automatic test_en_hold();
    int t0, bound;
    bound = 0;
    en = 1;
    do begin step(); bound++; end while (!frame_start && bound < 2 * FRAME);
    t0 = cyc;
    bound = 0;
    while (!(pixel_x == 8'd10 && pixel_y == 8'd1) && bound < 2 * FRAME) begin step(); bound++; end
    en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec() || pixel_x !== 8'd10 || data_en !== 1'b0) begin
        fails++;
        $display("FAIL en_hold i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    en = 1;
    step();
    checks++;
    if (dut_vec !== exp_vec() || pixel_x !== 8'd11 || data_en !== 1'b1) begin
      fails++;
      $display("FAIL en_resume got=%h exp=%h", dut_vec, exp_vec());
    end
    bound = 0;
    while (!frame_start && bound < 2 * FRAME) begin step(); bound++; end
    checks++;
    if (cyc - t0 != FRAME + 10) begin
      fails++;
      $display("FAIL en_stretch frame got=%0d exp=%0d", cyc - t0, FRAME + 10);
    end
  endtask

  task automatic test_async_reset();
    int bound = 0;
    en = 1;
    while (!(pixel_x == 8'(HA + HF + 1) && pixel_y == 8'(VA + VF + 1)) && bound < 2 * FRAME) begin
      step(); bound++;
    end
    checks++;
    if (VGA_HS !== HSP[0] || VGA_VS !== VSP[0] || pixel_x !== 8'(HA + HF + 1)) begin
      fails++;
      $display("FAIL mid_sync got hs=%0b vs=%0b x=%0d", VGA_HS, VGA_VS, pixel_x);
    end
    #2 rst = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      fails++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec, exp_vec());
    end
    step(); step();
    rst = 1;
    step();
    checks++;
    if (dut_vec !== exp_vec() || frame_start !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_fs got=%h exp=%h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 3 * HT; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL post_reset t=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_en_random();
    test_en_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
